// File: rtl/axi_lite_timer.sv
// rtl/axi_lite_timer.sv - AXI4-Lite memory-mapped 32-bit timer with prescaler, compare match and irq
module axi_lite_timer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]              axi_awprot,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]              axi_arprot,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic                    irq
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {R_CTRL, R_PRESCALE, R_COUNT, R_COMPARE, R_STATUS, R_NONE} reg_sel_e;

    function automatic reg_sel_e decode(input logic [IW-1:0] word);
        case (word)
            IW'(0):  return R_CTRL;
            IW'(1):  return R_PRESCALE;
            IW'(2):  return R_COUNT;
            IW'(3):  return R_COMPARE;
            IW'(4):  return R_STATUS;
            default: return R_NONE;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [2:0]            ctrl;
    logic [15:0]           prescale;
    logic [15:0]           psc;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, wr_fire, tick, hit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    reg_sel_e              wr_sel, rd_sel;
    logic [31:0]           rd_val;
    logic                  rd_err;
    logic                  unused_bits;

    assign axi_awready = !aw_held && !axi_bvalid;
    assign axi_wready  = !w_held && !axi_bvalid;
    assign axi_arready = !axi_rvalid;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    // The second half of a write may arrive this cycle, so use the live bus value when not yet held.
    assign wr_addr = aw_held ? aw_addr_q : axi_awaddr;
    assign wr_data = w_held ? w_data_q : axi_wdata;
    assign wr_strb = w_held ? w_strb_q : axi_wstrb;
    assign wr_fire = !axi_bvalid && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_sel  = decode(wr_addr[ADDR_WIDTH-1:2]);
    assign rd_sel  = decode(axi_araddr[ADDR_WIDTH-1:2]);

    assign tick = ctrl[0] && (psc == prescale);
    assign hit  = tick && (count == compare);

    assign unused_bits = ^{axi_awprot, axi_arprot, wr_addr[1:0], axi_araddr[1:0]};

    always_comb begin
        rd_val = 32'd0;
        rd_err = 1'b0;
        case (rd_sel)
            R_CTRL:     rd_val = {29'd0, ctrl};
            R_PRESCALE: rd_val = {16'd0, prescale};
            R_COUNT:    rd_val = count;
            R_COMPARE:  rd_val = compare;
            R_STATUS:   rd_val = {31'd0, match};
            default:    rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= 32'd0;
            w_strb_q   <= 4'd0;
            axi_bvalid <= 1'b0;
            axi_bresp  <= OKAY;
            axi_rvalid <= 1'b0;
            axi_rdata  <= 32'd0;
            axi_rresp  <= OKAY;
            ctrl       <= 3'd0;
            prescale   <= 16'd0;
            psc        <= 16'd0;
            count      <= 32'd0;
            compare    <= 32'd0;
            match      <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= axi_awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= axi_wdata;
                w_strb_q <= axi_wstrb;
            end
            if (wr_fire) begin
                axi_bvalid <= 1'b1;
                axi_bresp  <= (wr_sel == R_NONE) ? SLVERR : OKAY;
            end else if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
            end

            if (ar_hs) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= rd_val;
                axi_rresp  <= rd_err ? SLVERR : OKAY;
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end

            if (wr_fire && wr_sel == R_PRESCALE) psc <= 16'd0;
            else if (tick)                       psc <= 16'd0;
            else if (ctrl[0])                    psc <= psc + 16'd1;

            // A bus write to COUNT overrides the tick in the same cycle.
            if (wr_fire && wr_sel == R_COUNT) count <= merge(count, wr_data, wr_strb);
            else if (tick)                      count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;

            if (wr_fire && wr_sel == R_CTRL && wr_strb[0]) ctrl <= wr_data[2:0];
            if (wr_fire && wr_sel == R_PRESCALE) begin
                prescale <= {wr_strb[1] ? wr_data[15:8] : prescale[15:8],
                             wr_strb[0] ? wr_data[7:0]  : prescale[7:0]};
            end
            if (wr_fire && wr_sel == R_COMPARE) compare <= merge(compare, wr_data, wr_strb);

            if (hit) match <= 1'b1;
            else if (wr_fire && wr_sel == R_STATUS && wr_strb[0] && wr_data[0]) match <= 1'b0;

            irq <= match && ctrl[2];
        end
    end
endmodule

// File: tb/tb_axi_lite_timer.sv
// tb/tb_axi_lite_timer.sv - randomized and directed self-checking bench for axi_lite_timer
module tb_axi_lite_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  axi_awaddr, axi_araddr;
    logic [2:0]  axi_awprot, axi_arprot;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [31:0] axi_wdata, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        irq;

    axi_lite_timer #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_cyc = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: architectural registers plus bus bookkeeping, advanced once per clock.
    logic [2:0]  m_ctrl = 0;
    logic [15:0] m_pre = 0, m_psc = 0;
    logic [31:0] m_cnt = 0, m_cmp = 0, m_rdata = 0, m_wd = 0;
    logic        m_match = 0, m_irq = 0, m_awh = 0, m_wh = 0, m_bv = 0, m_rv = 0;
    logic [7:0]  m_awa = 0;
    logic [3:0]  m_ws = 0;
    logic [1:0]  m_bresp = 0, m_rresp = 0;
    logic        ev_aw = 0, ev_w = 0, ev_ar = 0, ev_b = 0;

    function automatic logic [32:0] model_read(input int off);
        case (off)
            0:       return {1'b0, 29'd0, m_ctrl};
            1:       return {1'b0, 16'd0, m_pre};
            2:       return {1'b0, m_cnt};
            3:       return {1'b0, m_cmp};
            4:       return {1'b0, 31'd0, m_match};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic awhs, whs, arhs, wr, tick, hit;
        logic [7:0] wa;
        logic [31:0] wd, nv;
        logic [3:0] ws;
        logic [32:0] rv;
        int off;
        if (reset) begin
            m_ctrl <= 0; m_pre <= 0; m_psc <= 0; m_cnt <= 0; m_cmp <= 0; m_match <= 0; m_irq <= 0;
            m_awh <= 0; m_wh <= 0; m_bv <= 0; m_rv <= 0; m_bresp <= 0; m_rresp <= 0; m_rdata <= 0;
            ev_aw <= 0; ev_w <= 0; ev_ar <= 0; ev_b <= 0;
        end else begin
            awhs = axi_awvalid && !m_awh && !m_bv;
            whs  = axi_wvalid && !m_wh && !m_bv;
            arhs = axi_arvalid && !m_rv;
            ev_aw <= awhs; ev_w <= whs; ev_ar <= arhs; ev_b <= m_bv && axi_bready;
            wa = m_awh ? m_awa : axi_awaddr;
            wd = m_wh ? m_wd : axi_wdata;
            ws = m_wh ? m_ws : axi_wstrb;
            wr = !m_bv && (m_awh || awhs) && (m_wh || whs);
            off = int'(wa[7:2]);
            tick = m_ctrl[0] && (m_psc == m_pre);
            hit = tick && (m_cnt == m_cmp);
            m_irq <= m_match && m_ctrl[2];
            if (arhs) begin
                rv = model_read(int'(axi_araddr[7:2]));
                m_rv <= 1; m_rdata <= rv[31:0]; m_rresp <= rv[32] ? 2'b10 : 2'b00;
            end else if (m_rv && axi_rready) m_rv <= 0;
            if (m_bv && axi_bready) begin m_bv <= 0; m_awh <= 0; m_wh <= 0; end
            if (awhs) begin m_awh <= 1; m_awa <= axi_awaddr; end
            if (whs) begin m_wh <= 1; m_wd <= axi_wdata; m_ws <= axi_wstrb; end
            if (m_ctrl[0]) m_psc <= tick ? 16'd0 : m_psc + 16'd1;
            if (tick) m_cnt <= (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
            if (hit) m_match <= 1;
            if (wr) begin
                m_bv <= 1;
                m_bresp <= (off > 4) ? 2'b10 : 2'b00;
                rv = model_read(off);
                nv = byte_merge(rv[31:0], wd, ws);
                case (off)
                    0: m_ctrl <= nv[2:0];
                    1: begin m_pre <= nv[15:0]; m_psc <= 0; end
                    2: m_cnt <= nv;
                    3: m_cmp <= nv;
                    4: if (ws[0] && wd[0] && !hit) m_match <= 0;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("awready", {31'd0, axi_awready}, {31'd0, !m_awh && !m_bv});
            chk("wready", {31'd0, axi_wready}, {31'd0, !m_wh && !m_bv});
            chk("arready", {31'd0, axi_arready}, {31'd0, !m_rv});
            chk("bvalid", {31'd0, axi_bvalid}, {31'd0, m_bv});
            chk("rvalid", {31'd0, axi_rvalid}, {31'd0, m_rv});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            if (m_bv) chk("bresp", {30'd0, axi_bresp}, {30'd0, m_bresp});
            if (m_rv) begin
                chk("rdata", axi_rdata, m_rdata);
                chk("rresp", {30'd0, axi_rresp}, {30'd0, m_rresp});
            end
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, output logic [1:0] resp, output int lat);
        bit awdone = 0;
        bit wdone = 0;
        int t = 0;
        lat = -1;
        resp = 2'b11;
        axi_bready = 1; axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        while (!(awdone && wdone) && t < 60) begin
            axi_awvalid = !awdone && (t >= awd);
            axi_wvalid  = !wdone && (t >= wd);
            @(negedge clk);
            t++;
            if (ev_aw) awdone = 1;
            if (ev_w) wdone = 1;
        end
        axi_awvalid = 0; axi_wvalid = 0;
        while (t < 120) begin
            if (axi_bvalid && lat < 0) begin lat = t; resp = axi_bresp; b_cyc = cyc; end
            if (ev_b) break;
            @(negedge clk);
            t++;
        end
        chk("write_completes", {31'd0, ev_b}, 32'd1);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int t = 0;
        axi_rready = 1; axi_araddr = a; axi_arvalid = 1;
        while (t < 60) begin
            @(negedge clk);
            t++;
            if (ev_ar) break;
        end
        axi_arvalid = 0;
        d = axi_rdata;
        r = axi_rresp;
        chk("read_completes", {31'd0, axi_rvalid}, 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_addr();
        int k;
        k = $urandom_range(0, 6);
        if (k <= 4) return 8'(k * 4 + $urandom_range(0, 3));
        if (k == 5) return 8'h20;
        return 8'($urandom);
    endfunction

    function automatic logic [31:0] rand_data();
        if ($urandom_range(0, 1) == 1) return 32'($urandom_range(0, 6));
        return $urandom;
    endfunction

    initial begin : stim
        logic [31:0] d;
        logic [1:0] r;
        int lat, t;
        bit got;
        reset = 1;
        axi_awaddr = 0; axi_awprot = 0; axi_awvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wvalid = 0;
        axi_bready = 1; axi_araddr = 0; axi_arprot = 0; axi_arvalid = 0; axi_rready = 1;
        repeat (3) @(negedge clk);
        chk_on = 1;
        reset = 0;
        chk("reset_awready", {31'd0, axi_awready}, 32'd1);
        chk("reset_wready", {31'd0, axi_wready}, 32'd1);
        chk("reset_arready", {31'd0, axi_arready}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            axi_read(8'(i * 4), d, r);
            chk("reset_read_data", d, 32'd0);
            chk("reset_read_resp", {30'd0, r}, 32'd0);
        end

        axi_write(8'h0C, 32'h0000_0005, 4'hF, 0, 3, r, lat);
        chk("aw_first_latency", lat, 4);
        chk("aw_first_bresp", {30'd0, r}, 32'd0);
        axi_read(8'h0C, d, r);
        chk("compare_readback_5", d, 32'h5);
        axi_write(8'h0C, 32'h0000_0009, 4'hF, 2, 0, r, lat);
        chk("w_first_latency", lat, 3);
        axi_read(8'h0C, d, r);
        chk("compare_readback_9", d, 32'h9);
        axi_write(8'h0C, 32'h1234_56FF, 4'b0001, 0, 0, r, lat);
        axi_read(8'h0C, d, r);
        chk("compare_strobe_byte0", d, 32'hFF);

        // Write response held back while a read goes through.
        axi_bready = 0; axi_awaddr = 8'h0C; axi_wdata = 32'hA5; axi_wstrb = 4'hF;
        axi_awvalid = 1; axi_wvalid = 1;
        @(negedge clk);
        axi_awvalid = 0; axi_wvalid = 0;
        axi_araddr = 8'h0C; axi_arvalid = 1; axi_rready = 1;
        got = 0; d = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bhold_bvalid", {31'd0, axi_bvalid}, 32'd1);
            chk("bhold_awready", {31'd0, axi_awready}, 32'd0);
            chk("bhold_wready", {31'd0, axi_wready}, 32'd0);
            if (ev_ar) axi_arvalid = 0;
            if (axi_rvalid && !got) begin got = 1; d = axi_rdata; end
        end
        chk("bhold_read_done", {31'd0, got}, 32'd1);
        chk("bhold_read_data", d, 32'hA5);
        axi_bready = 1;
        @(negedge clk);
        chk("bhold_ready_back", {31'd0, axi_awready && axi_wready}, 32'd1);

        axi_write(8'h08, 32'd0, 4'hF, 0, 0, r, lat);
        axi_write(8'h04, 32'd2, 4'hF, 0, 0, r, lat);
        axi_write(8'h0C, 32'd3, 4'hF, 0, 0, r, lat);
        axi_write(8'h00, 32'h7, 4'hF, 0, 0, r, lat);
        t = 0;
        while (!irq && t < 100) begin @(negedge clk); t++; end
        chk("irq_rise_delay", cyc - b_cyc, 13);
        axi_read(8'h10, d, r);
        chk("status_match", d, 32'h1);
        axi_write(8'h10, 32'h1, 4'hF, 0, 0, r, lat);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        axi_write(8'h00, 32'h0, 4'hF, 0, 0, r, lat);
        axi_write(8'h10, 32'h1, 4'hF, 0, 0, r, lat);
        axi_write(8'h04, 32'h0, 4'hF, 0, 0, r, lat);
        axi_write(8'h0C, 32'h0, 4'hF, 0, 0, r, lat);
        axi_write(8'h08, 32'hFFFF_FFFE, 4'hF, 0, 0, r, lat);
        axi_write(8'h00, 32'h1, 4'hF, 0, 0, r, lat);
        axi_read(8'h08, d, r);
        chk("count_pre_wrap", d, 32'hFFFF_FFFF);
        axi_read(8'h10, d, r);
        chk("wrap_match", d, 32'h1);
        chk("wrap_irq_masked", {31'd0, irq}, 32'd0);
        axi_write(8'h00, 32'h0, 4'hF, 0, 0, r, lat);

        axi_read(8'h20, d, r);
        chk("bad_read_data", d, 32'd0);
        chk("bad_read_resp", {30'd0, r}, 32'h2);
        axi_write(8'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat);
        chk("bad_write_resp", {30'd0, r}, 32'h2);
        axi_read(8'h0C, d, r);
        chk("bad_write_compare_kept", d, 32'd0);
        axi_read(8'h00, d, r);
        chk("bad_write_ctrl_kept", d, 32'd0);

        axi_rready = 0; axi_araddr = 8'h08; axi_arvalid = 1;
        t = 0;
        while (t < 20) begin @(negedge clk); t++; if (ev_ar) break; end
        axi_arvalid = 0;
        chk("rst_rvalid_pending", {31'd0, axi_rvalid}, 32'd1);
        reset = 1;
        @(negedge clk);
        chk("rst_rvalid_dropped", {31'd0, axi_rvalid}, 32'd0);
        reset = 0;
        axi_rready = 1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (axi_awvalid && ev_aw) axi_awvalid = 0;
            if (axi_wvalid && ev_w) axi_wvalid = 0;
            if (axi_arvalid && ev_ar) axi_arvalid = 0;
            if (!axi_awvalid && $urandom_range(0, 3) == 0) begin axi_awvalid = 1; axi_awaddr = rand_addr(); end
            if (!axi_wvalid && $urandom_range(0, 3) == 0) begin
                axi_wvalid = 1; axi_wdata = rand_data(); axi_wstrb = 4'($urandom);
            end
            if (!axi_arvalid && $urandom_range(0, 2) == 0) begin axi_arvalid = 1; axi_araddr = rand_addr(); end
            axi_bready = 1'($urandom);
            axi_rready = 1'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            if (reset) begin axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; end
        end
        reset = 0; axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; axi_bready = 1; axi_rready = 1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_timer.md
# axi_lite_timer

AXI4-Lite responder providing a memory-mapped 32-bit timer with a prescaler, compare match, and interrupt output. It attaches to the RISC_axi master bus alongside the ROM and RAM responders and is selected by the testbench/SoC address decode on its own base region. Software polls or takes the interrupt for periodic ticks. The master is the only initiator; this block never initiates transactions.

## Interface
- ADDR_WIDTH, 8: register-offset address bits decoded. Upper bits are stripped by the address decode.
- DATA_WIDTH, 32: bus data width. Only 32 is supported.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- axi_awaddr  in  ADDR_WIDTH  write address (offset).
- axi_awprot  in  3  ignored.
- axi_awvalid / axi_awready  in / out  1  write address handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables.
- axi_wvalid / axi_wready  in / out  1  write data handshake.
- axi_bresp  out  2  write response: OKAY=2'b00, SLVERR=2'b10.
- axi_bvalid / axi_bready  out / in  1  write response handshake.
- axi_araddr  in  ADDR_WIDTH  read address (offset).
- axi_arprot  in  3  ignored.
- axi_arvalid / axi_arready  in / out  1  read address handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid / axi_rready  out / in  1  read data handshake.
- irq  out  1  level interrupt.

## Operation
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: bits[15:0]; upper bits read 0.
  - 0x08 COUNT: 32-bit, read/write.
  - 0x0C COMPARE: 32-bit, read/write.
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
- Any other offset: reads return 0 with SLVERR; writes are discarded with SLVERR.
- wstrb is honoured per byte on CTRL, PRESCALE, COUNT and COMPARE. On STATUS, clear acts only if wstrb[0]=1.
- Prescaler psc (16-bit):
  - While EN=1, psc increments each cycle.
  - When psc==PRESCALE, psc wraps to 0 and a tick is generated. PRESCALE=0 gives a tick every cycle.
  - EN=0 holds both psc and COUNT.
- On a tick:
  - If COUNT==COMPARE, MATCH is set, and COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - COUNT wraps from 0xFFFFFFFF to 0.
- irq = MATCH & IRQ_EN, registered.
- Collisions:
  - A bus write to COUNT in the same cycle as a tick: the write wins.
  - A STATUS clear in the same cycle as a new match: the set wins.
  - Writing PRESCALE resets psc to 0.
- Write path: AW and W are captured independently into one-entry holding registers, in either order.
  - awready=1 when no AW is held and bvalid=0.
  - wready=1 when no W is held and bvalid=0.
- Read path: arready = !rvalid. Reads and writes proceed concurrently and independently.

## Timing
- Reset values: all registers 0, psc 0, irq 0, bvalid 0, rvalid 0, bresp 0, rresp 0, rdata 0. After reset, awready=1, wready=1, arready=1.
- Write:
  - Let N be the cycle in which the second of AW/W is held, or both handshake together.
  - At edge N+1 the register is updated, bvalid=1 and bresp is set; awready and wready drop.
  - bvalid holds until bready=1. The holding registers clear on that edge, and ready returns in the next cycle.
- Read:
  - AR handshake at cycle N gives rvalid=1 at N+1. rdata is the register value sampled at N.
  - rdata/rresp stay stable until rready=1.
- A read of COUNT in the same cycle as a write to COUNT returns the old value.
- irq rises one cycle after MATCH is set and falls one cycle after the clear.
- Reset asserted mid-transaction: pending AW/W/AR are dropped, and bvalid/rvalid drop at the next edge.

## Test plan
- Reset, then read all five registers → each returns 0x00000000 with rresp=OKAY; irq=0.
- Write AW at cycle 0 and W at cycle 3 to COMPARE with 0x0000_0005 and wstrb=4'hF → bvalid at cycle 4 with bresp=OKAY; readback 0x00000005. Repeat with W before AW, and with wstrb=4'b0001 writing 0xFF → COMPARE becomes 0x000000FF.
- PRESCALE=2, COMPARE=3, CTRL=0x7 → COUNT advances every 3 cycles. MATCH and irq are set after the tick at COUNT==3, and COUNT reloads to 0. Writing 0x1 to STATUS clears irq one cycle later.
- COUNT=0xFFFFFFFE, COMPARE=0, PRESCALE=0, EN only → COUNT goes 0xFFFFFFFF, then 0; MATCH is set on the tick at COUNT==0; irq stays 0 because IRQ_EN=0.
- Hold bready=0 for 5 cycles after a write → bvalid stays high, awready and wready stay low, and a concurrent read completes normally.
- Read offset 0x20 → rdata=0 with rresp=SLVERR. Write to 0x20 → bresp=SLVERR and all registers are unchanged. Assert reset while rvalid=1 with rready=0 → rvalid=0 at the next edge.
